mem_stage: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline. It consumes the EX/MEM latch outputs, performs load/store accesses to the data memory through a req/ack handshake with variable wait states, and resolves branch/jump redirection for fetch. It stalls upstream stages while an access is outstanding and registers results toward the write-back stage.

---
 rtl/mem_stage_pkg.sv | 12 +
 rtl/mem_timeout_ctr.sv | 37 +++
 rtl/mem_stage.sv | 211 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam int          DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts cycles while enabled; flags expiry on the TIMEOUT-th enabled cycle.
module mem_timeout_ctr
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  assign expired = enable && (count_q == CW'(TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-memory req/ack access, branch/jump redirect, registered WB outputs.
// Optional access timeout enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        branch,
  input  logic        jump,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic [31:0] adder,
  input  logic [1:0]  aluzero,
  input  logic [31:0] alu,
  input  logic [31:0] readdata2,
  input  logic [4:0]  mux,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        pc_src,
  output logic [31:0] pc_target,
  output logic        wb_valid,
  output logic        wb_RegWrite,
  output logic        wb_MemtoReg,
  output logic [31:0] wb_readdata,
  output logic [31:0] wb_alu,
  output logic [4:0]  wb_mux,
  output logic        mem_err
);

  state_e      state_q, state_d;

  logic [31:0] hold_alu_q, hold_alu_d;
  logic [31:0] hold_wdata_q, hold_wdata_d;
  logic        hold_we_q, hold_we_d;
  logic        hold_regwrite_q, hold_regwrite_d;
  logic        hold_memtoreg_q, hold_memtoreg_d;
  logic [4:0]  hold_mux_q, hold_mux_d;

  logic        wb_valid_q, wb_valid_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic        wb_memtoreg_q, wb_memtoreg_d;
  logic [31:0] wb_readdata_q, wb_readdata_d;
  logic [31:0] wb_alu_q, wb_alu_d;
  logic [4:0]  wb_mux_q, wb_mux_d;
  logic        pc_src_q, pc_src_d;
  logic [31:0] pc_target_q, pc_target_d;
  logic        mem_err_q, mem_err_d;

  logic        in_access;
  logic        mem_op;
  logic        timeout_hit;
  logic        unused_bits;

  assign in_access = (state_q == ST_ACCESS);
  assign mem_op    = MemRead | MemWrite;

`ifdef MEM_STAGE_TIMEOUT_EN
  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .reset   (reset),
    .clear   (!in_access),
    .enable  (in_access),
    .expired (timeout_hit)
  );
  assign unused_bits = aluzero[1];
`else
  assign timeout_hit = 1'b0;
  assign unused_bits = aluzero[1] ^ (TIMEOUT == 0);
`endif

  // Memory-side outputs come only from the holding registers so they stay stable until ack.
  always_comb begin
    dmem_req   = in_access;
    dmem_we    = in_access & hold_we_q;
    dmem_addr  = in_access ? (hold_alu_q & WORD_ALIGN_MASK) : 32'h0;
    dmem_wdata = in_access ? hold_wdata_q : 32'h0;
    stall      = !reset &&
                 (((state_q == ST_IDLE) && ex_valid && mem_op) ||
                  (in_access && !dmem_ack && !timeout_hit));
  end

  always_comb begin
    state_d         = state_q;
    hold_alu_d      = hold_alu_q;
    hold_wdata_d    = hold_wdata_q;
    hold_we_d       = hold_we_q;
    hold_regwrite_d = hold_regwrite_q;
    hold_memtoreg_d = hold_memtoreg_q;
    hold_mux_d      = hold_mux_q;
    wb_valid_d      = 1'b0;
    wb_regwrite_d   = wb_regwrite_q;
    wb_memtoreg_d   = wb_memtoreg_q;
    wb_readdata_d   = wb_readdata_q;
    wb_alu_d        = wb_alu_q;
    wb_mux_d        = wb_mux_q;
    pc_src_d        = 1'b0;
    pc_target_d     = pc_target_q;
    mem_err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          if (mem_op) begin
            // A read+write combination is carried out as a write.
            hold_alu_d      = alu;
            hold_wdata_d    = readdata2;
            hold_we_d       = MemWrite;
            hold_regwrite_d = RegWrite;
            hold_memtoreg_d = MemtoReg;
            hold_mux_d      = mux;
            state_d         = ST_ACCESS;
          end else begin
            wb_valid_d    = 1'b1;
            wb_regwrite_d = RegWrite;
            wb_memtoreg_d = MemtoReg;
            wb_readdata_d = 32'h0;
            wb_alu_d      = alu;
            wb_mux_d      = mux;
            pc_src_d      = jump | (branch & aluzero[0]);
            pc_target_d   = adder;
          end
        end
      end

      ST_ACCESS: begin
        if (dmem_ack) begin
          state_d       = ST_IDLE;
          wb_valid_d    = 1'b1;
          wb_regwrite_d = hold_regwrite_q;
          wb_memtoreg_d = hold_memtoreg_q;
          wb_readdata_d = hold_we_q ? 32'h0 : dmem_rdata;
          wb_alu_d      = hold_alu_q;
          wb_mux_d      = hold_mux_q;
        end else if (timeout_hit) begin
          // Aborted access still retires so the pipeline drains, but never writes a register.
          state_d       = ST_IDLE;
          wb_valid_d    = 1'b1;
          wb_regwrite_d = 1'b0;
          wb_memtoreg_d = hold_memtoreg_q;
          wb_readdata_d = 32'h0;
          wb_alu_d      = hold_alu_q;
          wb_mux_d      = hold_mux_q;
          mem_err_d     = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      hold_alu_q      <= 32'h0;
      hold_wdata_q    <= 32'h0;
      hold_we_q       <= 1'b0;
      hold_regwrite_q <= 1'b0;
      hold_memtoreg_q <= 1'b0;
      hold_mux_q      <= 5'h0;
      wb_valid_q      <= 1'b0;
      wb_regwrite_q   <= 1'b0;
      wb_memtoreg_q   <= 1'b0;
      wb_readdata_q   <= 32'h0;
      wb_alu_q        <= 32'h0;
      wb_mux_q        <= 5'h0;
      pc_src_q        <= 1'b0;
      pc_target_q     <= 32'h0;
      mem_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      hold_alu_q      <= hold_alu_d;
      hold_wdata_q    <= hold_wdata_d;
      hold_we_q       <= hold_we_d;
      hold_regwrite_q <= hold_regwrite_d;
      hold_memtoreg_q <= hold_memtoreg_d;
      hold_mux_q      <= hold_mux_d;
      wb_valid_q      <= wb_valid_d;
      wb_regwrite_q   <= wb_regwrite_d;
      wb_memtoreg_q   <= wb_memtoreg_d;
      wb_readdata_q   <= wb_readdata_d;
      wb_alu_q        <= wb_alu_d;
      wb_mux_q        <= wb_mux_d;
      pc_src_q        <= pc_src_d;
      pc_target_q     <= pc_target_d;
      mem_err_q       <= mem_err_d;
    end
  end

  assign wb_valid    = wb_valid_q;
  assign wb_RegWrite = wb_regwrite_q;
  assign wb_MemtoReg = wb_memtoreg_q;
  assign wb_readdata = wb_readdata_q;
  assign wb_alu      = wb_alu_q;
  assign wb_mux      = wb_mux_q;
  assign pc_src      = pc_src_q;
  assign pc_target   = pc_target_q;
  assign mem_err     = mem_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: random instruction stream, behavioural memory model,
// randomized wait states; timeout scenario is exercised when MEM_STAGE_TIMEOUT_EN is defined.
module tb_mem_stage;

  localparam int TB_TIMEOUT = 4;

  typedef struct {
    logic        branch, jump, mem_read, mem_write, reg_write, mem_to_reg;
    logic [31:0] adder;
    logic [1:0]  aluzero;
    logic [31:0] alu, rd2;
    logic [4:0]  mux;
    int          wait_n;
  } instr_t;

  typedef struct {
    logic [31:0] readdata, alu, pc_target;
    logic [4:0]  mux;
    logic        reg_write, mem_to_reg, pc_src, mem_err;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr, wdata;
    logic        we;
    int          wait_n;
  } acc_t;

  logic        clk, reset;
  logic        ex_valid, branch, jump, MemRead, MemWrite, RegWrite, MemtoReg;
  logic [31:0] adder, alu, readdata2;
  logic [1:0]  aluzero;
  logic [4:0]  mux;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall, pc_src, wb_valid, wb_RegWrite, wb_MemtoReg, mem_err;
  logic [31:0] pc_target, wb_readdata, wb_alu;
  logic [4:0]  wb_mux;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  exp_t scq[$];
  acc_t accq[$];
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] dmem    [int unsigned];

  mem_stage #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid),
    .branch(branch), .jump(jump), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .adder(adder), .aluzero(aluzero),
    .alu(alu), .readdata2(readdata2), .mux(mux),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .pc_src(pc_src), .pc_target(pc_target),
    .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
    .wb_readdata(wb_readdata), .wb_alu(wb_alu), .wb_mux(wb_mux), .mem_err(mem_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] initWord(input int unsigned key);
    return key * 32'h9E37_79B9 + 32'h1357;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] addr);
    int unsigned key = addr >> 2;
    return ref_mem.exists(key) ? ref_mem[key] : initWord(key);
  endfunction

  function automatic logic [31:0] dmemRead(input logic [31:0] addr);
    int unsigned key = addr >> 2;
    return dmem.exists(key) ? dmem[key] : initWord(key);
  endfunction

  function automatic bit timedOut(input int w);
`ifdef MEM_STAGE_TIMEOUT_EN
    return w >= TB_TIMEOUT;
`else
    return (w < 0);
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Issues one instruction, records expectations, and waits until the stage consumes it.
  task automatic applyStimulus(input instr_t t);
    exp_t e;
    acc_t a;
    int   n_stall = 0;
    int   exp_stall;
    int   guard = 0;
    logic s;
    bit   to;

    ex_valid = 1; branch = t.branch; jump = t.jump; MemRead = t.mem_read;
    MemWrite = t.mem_write; RegWrite = t.reg_write; MemtoReg = t.mem_to_reg;
    adder = t.adder; aluzero = t.aluzero; alu = t.alu; readdata2 = t.rd2; mux = t.mux;

    e.alu = t.alu; e.mux = t.mux; e.mem_to_reg = t.mem_to_reg; e.pc_target = t.adder;
    if (!(t.mem_read || t.mem_write)) begin
      e.readdata  = 0;
      e.reg_write = t.reg_write;
      e.pc_src    = t.jump | (t.branch & t.aluzero[0]);
      e.mem_err   = 0;
      e.cyc       = cyc + 1;
      exp_stall   = 0;
    end else begin
      to = timedOut(t.wait_n);
      a.addr = {t.alu[31:2], 2'b00}; a.we = t.mem_write; a.wdata = t.rd2; a.wait_n = t.wait_n;
      accq.push_back(a);
      e.pc_src    = 0;
      e.mem_err   = to;
      e.reg_write = to ? 1'b0 : t.reg_write;
      e.readdata  = (to || t.mem_write) ? 32'h0 : refRead(t.alu);
      if (!to && t.mem_write) ref_mem[t.alu >> 2] = t.rd2;
      e.cyc     = to ? cyc + 1 + TB_TIMEOUT : cyc + 2 + t.wait_n;
      exp_stall = to ? TB_TIMEOUT : 1 + t.wait_n;
    end
    scq.push_back(e);

    forever begin
      @(negedge clk);
      s = stall;
      if (s) n_stall++;
      @(posedge clk); #1;
      if (!s) break;
      if (++guard > 200) begin
        errors++;
        $display("[TB] FAIL stall_timeout: stall still high after %0d cycles, required release", guard);
        break;
      end
    end
    checkOutput("stall_cycles", n_stall, exp_stall);
  endtask

  task automatic applyIdle(input int n);
    ex_valid = 0; branch = $urandom; jump = $urandom; MemRead = $urandom; MemWrite = $urandom;
    alu = $urandom; adder = $urandom;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops an expectation whenever the stage retires an instruction.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (wb_valid) begin
        if (scq.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL wb_unexpected: actual wb_valid=1 required no retirement");
        end else begin
          e = scq.pop_front();
          checkOutput("wb_latency_cycle", cyc, e.cyc);
          checkOutput("wb_alu", wb_alu, e.alu);
          checkOutput("wb_mux", {27'b0, wb_mux}, {27'b0, e.mux});
          checkOutput("wb_RegWrite", {31'b0, wb_RegWrite}, {31'b0, e.reg_write});
          checkOutput("wb_MemtoReg", {31'b0, wb_MemtoReg}, {31'b0, e.mem_to_reg});
          checkOutput("wb_readdata", wb_readdata, e.readdata);
          checkOutput("pc_src", {31'b0, pc_src}, {31'b0, e.pc_src});
          checkOutput("mem_err", {31'b0, mem_err}, {31'b0, e.mem_err});
          if (e.pc_src) checkOutput("pc_target", pc_target, e.pc_target);
        end
      end else begin
        checkOutput("pc_src_quiet", {31'b0, pc_src}, 32'h0);
        checkOutput("mem_err_quiet", {31'b0, mem_err}, 32'h0);
      end
    end
  end

  // Memory responder: waits the requested number of cycles, checks request fields each cycle.
  initial begin
    acc_t cur;
    bit   active = 0;
    int   wcnt = 0;
    dmem_ack = 0; dmem_rdata = 0;
    cur = '{addr: 0, wdata: 0, we: 0, wait_n: 0};
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        active = 0; dmem_ack = 0; accq.delete();
      end else if (dmem_req) begin
        if (!active) begin
          if (accq.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL dmem_unexpected_req: actual req=1 addr=%h required no request", dmem_addr);
            cur = '{addr: dmem_addr, wdata: dmem_wdata, we: dmem_we, wait_n: 0};
          end else begin
            cur = accq.pop_front();
          end
          active = 1; wcnt = 0;
        end
        checkOutput("dmem_addr", dmem_addr, cur.addr);
        checkOutput("dmem_we", {31'b0, dmem_we}, {31'b0, cur.we});
        if (cur.we) checkOutput("dmem_wdata", dmem_wdata, cur.wdata);
        if (wcnt == cur.wait_n) begin
          dmem_ack   = 1;
          dmem_rdata = dmem_we ? $urandom : dmemRead(dmem_addr);
          if (dmem_we) dmem[dmem_addr >> 2] = dmem_wdata;
          active = 0;
        end else begin
          dmem_ack = 0; dmem_rdata = $urandom; wcnt++;
        end
      end else begin
        active = 0;
        dmem_ack = ($urandom_range(0, 3) == 0);
        dmem_rdata = $urandom;
      end
    end
  end

  initial begin
    instr_t t;
    int guard;

    reset = 1;
    ex_valid = 0; branch = 0; jump = 0; MemRead = 0; MemWrite = 0; RegWrite = 0; MemtoReg = 0;
    adder = 0; aluzero = 0; alu = 0; readdata2 = 0; mux = 0;
    #3;
    checkOutput("reset_dmem_req", {31'b0, dmem_req}, 32'h0);
    checkOutput("reset_stall", {31'b0, stall}, 32'h0);
    checkOutput("reset_wb_valid", {31'b0, wb_valid}, 32'h0);
    checkOutput("reset_pc_src", {31'b0, pc_src}, 32'h0);
    checkOutput("reset_pc_target", pc_target, 32'h0);
    checkOutput("reset_wb_alu", wb_alu, 32'h0);
    checkOutput("reset_wb_readdata", wb_readdata, 32'h0);
    checkOutput("reset_mem_err", {31'b0, mem_err}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    applyIdle(2);

    // Reset asserted in the middle of an outstanding load.
    ex_valid = 1; MemRead = 1; MemWrite = 0; RegWrite = 1; alu = 32'h0000_0200; mux = 7;
    accq.push_back('{addr: 32'h200, wdata: 0, we: 0, wait_n: 20});
    @(posedge clk); #1;
    checkOutput("access_dmem_req", {31'b0, dmem_req}, 32'h1);
    checkOutput("access_dmem_addr", dmem_addr, 32'h200);
    @(negedge clk); #2;
    reset = 1; ex_valid = 0;
    #1;
    checkOutput("midreset_dmem_req", {31'b0, dmem_req}, 32'h0);
    checkOutput("midreset_stall", {31'b0, stall}, 32'h0);
    checkOutput("midreset_wb_valid", {31'b0, wb_valid}, 32'h0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    checkOutput("postreset_idle_req", {31'b0, dmem_req}, 32'h0);
    @(posedge clk); #1;

    // Directed cases.
    t = '{branch: 0, jump: 0, mem_read: 0, mem_write: 0, reg_write: 1, mem_to_reg: 0,
          adder: 32'h0, aluzero: 2'b00, alu: 32'h10, rd2: 32'h0, mux: 5, wait_n: 0};
    applyStimulus(t);
    ref_mem[32'h40] = 32'hDEAD_BEEF;
    dmem[32'h40]    = 32'hDEAD_BEEF;
    t = '{branch: 0, jump: 0, mem_read: 1, mem_write: 0, reg_write: 1, mem_to_reg: 1,
          adder: 32'h0, aluzero: 2'b00, alu: 32'h103, rd2: 32'h0, mux: 9, wait_n: 3};
    applyStimulus(t);
    t = '{branch: 0, jump: 0, mem_read: 0, mem_write: 1, reg_write: 0, mem_to_reg: 0,
          adder: 32'h0, aluzero: 2'b00, alu: 32'h80, rd2: 32'h1234_5678, mux: 0, wait_n: 0};
    applyStimulus(t);
    t = '{branch: 1, jump: 0, mem_read: 0, mem_write: 0, reg_write: 0, mem_to_reg: 0,
          adder: 32'h40, aluzero: 2'b01, alu: 32'h0, rd2: 32'h0, mux: 0, wait_n: 0};
    applyStimulus(t);
    applyIdle(1);
    t.aluzero = 2'b10; t.adder = 32'h44;
    applyStimulus(t);
    t = '{branch: 1, jump: 1, mem_read: 1, mem_write: 1, reg_write: 1, mem_to_reg: 0,
          adder: 32'h88, aluzero: 2'b01, alu: 32'h80, rd2: 32'hCAFE_0001, mux: 3, wait_n: 1};
    applyStimulus(t);
    t.mem_write = 0; t.jump = 0; t.wait_n = 2;
    applyStimulus(t);
`ifdef MEM_STAGE_TIMEOUT_EN
    t = '{branch: 0, jump: 0, mem_read: 1, mem_write: 0, reg_write: 1, mem_to_reg: 1,
          adder: 32'h0, aluzero: 2'b00, alu: 32'h300, rd2: 32'h0, mux: 4, wait_n: 1000};
    applyStimulus(t);
`endif

    // Randomized instruction stream.
    for (int i = 0; i < 120; i++) begin
      t.branch     = $urandom; t.jump = ($urandom_range(0, 3) == 0);
      t.mem_read   = ($urandom_range(0, 2) == 0);
      t.mem_write  = ($urandom_range(0, 2) == 0);
      t.reg_write  = $urandom; t.mem_to_reg = $urandom;
      t.adder      = $urandom; t.aluzero = 2'($urandom);
      t.alu        = $urandom_range(0, 255); t.rd2 = $urandom; t.mux = 5'($urandom);
      t.wait_n     = $urandom_range(0, 5);
      applyStimulus(t);
      if ($urandom_range(0, 4) == 0) applyIdle($urandom_range(1, 3));
    end

    applyIdle(2);
    guard = 0;
    while (scq.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (scq.size() != 0) begin
      checks++; errors++;
      $display("[TB] FAIL scoreboard_drain: actual %0d pending required 0", scq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
